// File: rtl/tmds_pkg.sv
// Shared TMDS word width, control-token constants, alignment FSM states and token test.
package tmds_pkg;

  localparam int TMDS_WORD_W = 10;

  localparam logic [TMDS_WORD_W-1:0] CTRL_TOK_00 = 10'h354;
  localparam logic [TMDS_WORD_W-1:0] CTRL_TOK_01 = 10'h0AB;
  localparam logic [TMDS_WORD_W-1:0] CTRL_TOK_10 = 10'h154;
  localparam logic [TMDS_WORD_W-1:0] CTRL_TOK_11 = 10'h2AB;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } tmds_state_e;

  function automatic logic is_ctrl_token(input logic [TMDS_WORD_W-1:0] w);
    return (w == CTRL_TOK_00) || (w == CTRL_TOK_01) ||
           (w == CTRL_TOK_10) || (w == CTRL_TOK_11);
  endfunction

endpackage

// File: rtl/tmds_deserializer_if.sv
// Serial input and aligned-symbol outputs of the TMDS deserializer.
// Decoded pixel/sync signals exist only when TMDS_DECODE_EN is defined.
interface tmds_deserializer_if;
  import tmds_pkg::*;

  logic [2:0]             serial_in;
  logic [TMDS_WORD_W-1:0] tmds_red;
  logic [TMDS_WORD_W-1:0] tmds_green;
  logic [TMDS_WORD_W-1:0] tmds_blue;
  logic                   word_valid;
  logic                   locked;
`ifdef TMDS_DECODE_EN
  logic [7:0]             red_data;
  logic [7:0]             green_data;
  logic [7:0]             blue_data;
  logic                   de;
  logic                   hsync;
  logic                   vsync;

  modport master (output serial_in,
                  input  tmds_red, tmds_green, tmds_blue, word_valid, locked,
                  input  red_data, green_data, blue_data, de, hsync, vsync);
  modport slave  (input  serial_in,
                  output tmds_red, tmds_green, tmds_blue, word_valid, locked,
                  output red_data, green_data, blue_data, de, hsync, vsync);
`else
  modport master (output serial_in,
                  input  tmds_red, tmds_green, tmds_blue, word_valid, locked);
  modport slave  (input  serial_in,
                  output tmds_red, tmds_green, tmds_blue, word_valid, locked);
`endif

endinterface

// File: rtl/tmds_decode.sv
// Combinational 10b->8b TMDS decode with control-token (de/C1:C0) extraction.
// Only built when TMDS_DECODE_EN is defined.
`ifdef TMDS_DECODE_EN
module tmds_decode
  import tmds_pkg::*;
(
  input  logic [TMDS_WORD_W-1:0] sym_i,
  output logic [7:0]             data_o,
  output logic                   de_o,
  output logic [1:0]             ctrl_o
);

  logic [7:0] q;

  always_comb begin
    q         = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];
    data_o    = 8'd0;
    data_o[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      data_o[i] = sym_i[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    de_o = !is_ctrl_token(sym_i);
    case (sym_i)
      CTRL_TOK_01: ctrl_o = 2'b01;
      CTRL_TOK_10: ctrl_o = 2'b10;
      CTRL_TOK_11: ctrl_o = 2'b11;
      default:     ctrl_o = 2'b00;
    endcase
  end

endmodule
`endif

// File: rtl/tmds_deserializer.sv
// TMDS receiver: aligns 10-bit words on blue-channel control tokens and strobes symbols.
// Optional per-channel decode to pixel/de/sync when TMDS_DECODE_EN is defined.
module tmds_deserializer
  import tmds_pkg::*;
#(
  parameter int CTRL_LOCK_COUNT = 4,
  parameter int LOSS_TIMEOUT    = 2048
) (
  input logic               clk_fast,
  input logic               rst,
  tmds_deserializer_if.slave rx
);

  // state  | meaning
  // SEARCH | test blue every cycle for a token to seed the word phase
  // VERIFY | count tokens on boundaries until CTRL_LOCK_COUNT is seen
  // LOCKED | emit symbols each boundary, drop after LOSS_TIMEOUT token-less words
  localparam logic [2:0]  LOCK_CNT = 3'(CTRL_LOCK_COUNT);
  localparam logic [11:0] LOSS_CNT = 12'(LOSS_TIMEOUT);

  tmds_state_e            state_q, state_d;
  logic [TMDS_WORD_W-1:0] sh_r_q, sh_g_q, sh_b_q;
  logic [TMDS_WORD_W-1:0] tmds_r_q, tmds_g_q, tmds_b_q;
  logic [3:0]             phase_q, phase_d;
  logic [2:0]             tok_cnt_q, tok_cnt_d, tok_inc;
  logic [11:0]            miss_cnt_q, miss_cnt_d, miss_inc;
  logic                   locked_q, wv_q;
  logic                   boundary, blue_tok, emit;

  always_comb begin
    boundary   = (phase_q == 4'd9);
    blue_tok   = is_ctrl_token(sh_b_q);
    tok_inc    = (tok_cnt_q == 3'd7) ? tok_cnt_q : tok_cnt_q + 3'd1;
    miss_inc   = (miss_cnt_q == 12'hFFF) ? miss_cnt_q : miss_cnt_q + 12'd1;
    state_d    = state_q;
    phase_d    = boundary ? 4'd0 : phase_q + 4'd1;
    tok_cnt_d  = tok_cnt_q;
    miss_cnt_d = miss_cnt_q;
    emit       = 1'b0;
    case (state_q)
      SEARCH: begin
        if (blue_tok) begin
          phase_d   = 4'd0;
          tok_cnt_d = 3'd1;
          state_d   = VERIFY;
        end
      end
      VERIFY: begin
        if (boundary) begin
          if (blue_tok) begin
            tok_cnt_d = tok_inc;
            if (tok_inc >= LOCK_CNT) begin
              state_d    = LOCKED;
              miss_cnt_d = 12'd0;
            end
          end else begin
            state_d = SEARCH;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          if (blue_tok) begin
            miss_cnt_d = 12'd0;
            emit       = 1'b1;
          end else begin
            miss_cnt_d = miss_inc;
            if (miss_inc >= LOSS_CNT) state_d = SEARCH;
            else                      emit    = 1'b1;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      state_q    <= SEARCH;
      sh_r_q     <= '0;
      sh_g_q     <= '0;
      sh_b_q     <= '0;
      tmds_r_q   <= '0;
      tmds_g_q   <= '0;
      tmds_b_q   <= '0;
      phase_q    <= 4'd0;
      tok_cnt_q  <= 3'd0;
      miss_cnt_q <= 12'd0;
      locked_q   <= 1'b0;
      wv_q       <= 1'b0;
    end else begin
      sh_r_q     <= {rx.serial_in[2], sh_r_q[TMDS_WORD_W-1:1]};
      sh_g_q     <= {rx.serial_in[1], sh_g_q[TMDS_WORD_W-1:1]};
      sh_b_q     <= {rx.serial_in[0], sh_b_q[TMDS_WORD_W-1:1]};
      state_q    <= state_d;
      phase_q    <= phase_d;
      tok_cnt_q  <= tok_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      locked_q   <= (state_d == LOCKED);
      wv_q       <= emit;
      if (emit) begin
        tmds_r_q <= sh_r_q;
        tmds_g_q <= sh_g_q;
        tmds_b_q <= sh_b_q;
      end
    end
  end

  assign rx.tmds_red   = tmds_r_q;
  assign rx.tmds_green = tmds_g_q;
  assign rx.tmds_blue  = tmds_b_q;
  assign rx.word_valid = wv_q;
  assign rx.locked     = locked_q;

`ifdef TMDS_DECODE_EN
  logic [7:0] r_dat, g_dat, b_dat;
  logic       r_de, g_de, b_de;
  logic [1:0] r_ctrl, g_ctrl, b_ctrl;
  logic [7:0] r_data_q, g_data_q, b_data_q;
  logic       de_q, hsync_q, vsync_q;
  logic       unused_rg_ctrl;

  tmds_decode u_dec_r (.sym_i(sh_r_q), .data_o(r_dat), .de_o(r_de), .ctrl_o(r_ctrl));
  tmds_decode u_dec_g (.sym_i(sh_g_q), .data_o(g_dat), .de_o(g_de), .ctrl_o(g_ctrl));
  tmds_decode u_dec_b (.sym_i(sh_b_q), .data_o(b_dat), .de_o(b_de), .ctrl_o(b_ctrl));

  // Sync comes from blue only; red/green control codes carry no meaning here.
  assign unused_rg_ctrl = ^{r_ctrl, g_ctrl, r_de, g_de};

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      r_data_q <= 8'd0;
      g_data_q <= 8'd0;
      b_data_q <= 8'd0;
      de_q     <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
    end else if (emit) begin
      r_data_q <= r_dat;
      g_data_q <= g_dat;
      b_data_q <= b_dat;
      de_q     <= b_de;
      if (!b_de) begin
        hsync_q <= b_ctrl[0];
        vsync_q <= b_ctrl[1];
      end
    end
  end

  assign rx.red_data   = r_data_q;
  assign rx.green_data = g_data_q;
  assign rx.blue_data  = b_data_q;
  assign rx.de         = de_q;
  assign rx.hsync      = hsync_q;
  assign rx.vsync      = vsync_q;
`endif

endmodule

// File: tb/tb_tmds_deserializer.sv
// Directed bench for tmds_deserializer: lock acquisition, data, sync, loss of lock, reset.
module tb_tmds_deserializer;

  logic clk_fast = 1'b0;
  logic rst      = 1'b1;

  always #5 clk_fast = ~clk_fast;

  tmds_deserializer_if bus ();

  tmds_deserializer dut (
    .clk_fast (clk_fast),
    .rst      (rst),
    .rx       (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Observation state filled by send_word while it streams one word.
  int         cap_idx = 1;
  int         wv_n, wv_at, wv_total;
  logic       lk0, lk_c, wv_c, any_lk;
  logic [9:0] cap_r, cap_g, cap_b;
`ifdef TMDS_DECODE_EN
  logic [7:0] cap_rd, cap_gd, cap_bd;
  logic       cap_de, cap_hs, cap_vs;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Streams one word per channel LSB first; samples DUT at negedge before driving.
  task automatic send_word(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                           input int rst_at);
    wv_n  = 0;
    wv_at = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_fast);
      if (i == 0) lk0 = bus.locked;
      if (i == cap_idx) begin
        lk_c  = bus.locked;
        wv_c  = bus.word_valid;
        cap_r = bus.tmds_red;
        cap_g = bus.tmds_green;
        cap_b = bus.tmds_blue;
`ifdef TMDS_DECODE_EN
        cap_rd = bus.red_data;
        cap_gd = bus.green_data;
        cap_bd = bus.blue_data;
        cap_de = bus.de;
        cap_hs = bus.hsync;
        cap_vs = bus.vsync;
`endif
      end
      if (bus.word_valid) begin
        wv_n++;
        wv_at = i;
        wv_total++;
      end
      any_lk = any_lk | bus.locked;
      if (i == rst_at) rst = 1'b1;
      else if (rst_at >= 0 && i == rst_at + 1) rst = 1'b0;
      bus.serial_in = {r[i], g[i], b[i]};
    end
  endtask

  task automatic tok(input logic [9:0] t);
    send_word(t, t, t, -1);
  endtask

  task automatic do_reset();
    @(negedge clk_fast);
    rst           = 1'b1;
    bus.serial_in = 3'b000;
    repeat (2) @(negedge clk_fast);
    rst = 1'b0;
  endtask

  // Four tokens, then a fifth word during which locked must rise at offset 1.
  task automatic acquire(input logic [9:0] t, input string tag);
    any_lk = 1'b0;
    repeat (4) tok(t);
    check_eq({tag, " no lock before 4th boundary"}, 32'(any_lk), 32'd0);
    tok(t);
    check_eq({tag, " locked rises E+1"}, 32'({lk0, lk_c}), 32'b01);
    check_eq({tag, " no strobe on lock boundary"}, 32'(wv_n), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.serial_in = 3'b000;
    wv_total      = 0;

    @(negedge clk_fast);
    @(negedge clk_fast);
    check_eq("reset locked/word_valid", 32'({bus.locked, bus.word_valid}), 32'd0);
    check_eq("reset tmds_blue", 32'(bus.tmds_blue), 32'd0);
    check_eq("reset tmds_red/green", 32'({bus.tmds_red, bus.tmds_green}), 32'd0);
    do_reset();

    for (int k = 0; k < 10; k++) begin
      do_reset();
      repeat (k) @(negedge clk_fast);
      acquire(10'h354, $sformatf("off%0d", k));
      tok(10'h354);
      check_eq($sformatf("off%0d one strobe at offset 1", k), 32'({wv_n[3:0], wv_at[3:0]}),
               32'h11);
      check_eq($sformatf("off%0d tmds_blue", k), 32'(cap_b), 32'h354);
    end

    do_reset();
    any_lk = 1'b0;
    repeat (3) tok(10'h354);
    tok(10'h3FF);
    repeat (4) tok(10'h354);
    check_eq("corrupt never locked", 32'(any_lk), 32'd0);
    tok(10'h354);
    check_eq("corrupt relock", 32'(lk_c), 32'd1);

    do_reset();
    acquire(10'h354, "data");
    send_word(10'h1A5, 10'h2FF, 10'h100, -1);
    send_word(10'h2CC, 10'h100, 10'h2FF, -1);
    check_eq("data1 tmds b/g/r", 32'({2'b00, cap_b, cap_g, cap_r}),
             32'({2'b00, 10'h100, 10'h2FF, 10'h1A5}));
`ifdef TMDS_DECODE_EN
    check_eq("data1 decode b/g/r/de", 32'({cap_bd, cap_gd, cap_rd, cap_de}),
             32'({8'h00, 8'hFE, 8'hEF, 1'b1}));
`endif
    tok(10'h354);
    check_eq("data2 tmds b/g/r", 32'({2'b00, cap_b, cap_g, cap_r}),
             32'({2'b00, 10'h2FF, 10'h100, 10'h2CC}));
`ifdef TMDS_DECODE_EN
    check_eq("data2 decode b/g/r/de", 32'({cap_bd, cap_gd, cap_rd, cap_de}),
             32'({8'hFE, 8'h00, 8'hAB, 1'b1}));
`endif

    do_reset();
    acquire(10'h0AB, "sync");
    tok(10'h2AB);
    check_eq("sync C01 tmds_blue", 32'(cap_b), 32'h0AB);
`ifdef TMDS_DECODE_EN
    check_eq("sync C01 de/h/v", 32'({cap_de, cap_hs, cap_vs}), 32'b010);
`endif
    send_word(10'h100, 10'h100, 10'h100, -1);
    check_eq("sync C11 tmds_blue", 32'(cap_b), 32'h2AB);
`ifdef TMDS_DECODE_EN
    check_eq("sync C11 de/h/v", 32'({cap_de, cap_hs, cap_vs}), 32'b011);
`endif
    send_word(10'h100, 10'h100, 10'h100, -1);
`ifdef TMDS_DECODE_EN
    check_eq("sync hold during data de/h/v", 32'({cap_de, cap_hs, cap_vs}), 32'b111);
`endif
    check_eq("sync data tmds_blue", 32'(cap_b), 32'h100);

    do_reset();
    repeat (4) tok(10'h354);
    wv_total = 0;
    repeat (2048) send_word(10'h100, 10'h100, 10'h100, -1);
    check_eq("loss strobes before timeout", 32'(wv_total), 32'd2047);
    send_word(10'h100, 10'h100, 10'h100, -1);
    check_eq("loss locked drops at E+1", 32'({lk0, lk_c}), 32'b10);
    check_eq("loss no strobe on timeout", 32'(wv_n), 32'd0);
    check_eq("loss tmds_blue held", 32'(cap_b), 32'h100);

    do_reset();
    repeat (4) tok(10'h354);
    repeat (2047) send_word(10'h100, 10'h100, 10'h100, -1);
    tok(10'h354);
    send_word(10'h100, 10'h100, 10'h100, -1);
    check_eq("token at timeout keeps lock", 32'({lk_c, wv_c}), 32'b11);
    check_eq("token at timeout emitted", 32'(cap_b), 32'h354);

    cap_idx = 6;
    send_word(10'h354, 10'h354, 10'h354, 5);
    check_eq("midrst locked/word_valid", 32'({lk_c, wv_c}), 32'd0);
    check_eq("midrst tmds b/g/r", 32'({2'b00, cap_b, cap_g, cap_r}), 32'd0);
`ifdef TMDS_DECODE_EN
    check_eq("midrst decode", 32'({cap_bd, cap_gd, cap_rd, cap_de, cap_hs, cap_vs}), 32'd0);
`endif
    cap_idx = 1;
    acquire(10'h354, "midrst relock");
    tok(10'h354);
    check_eq("midrst relock strobe", 32'({wv_n[3:0], wv_at[3:0]}), 32'h11);
    check_eq("midrst relock tmds_blue", 32'(cap_b), 32'h354);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
